led_palette_fader: RTL and testbench

- Sequencer that owns the palette inputs of the LED PWM driver. It drives the 8-bit red/green/blue values for each color LED and the luminance value for each basic LED.
- Arbitrates between two requesters, each supplying a target palette over a valid/ready handshake.
- Ramps every channel toward its target by one LSB per fade tick, then reports completion.
- Sits between the application FSMs (status display, accelerometer display) and led_pwm_driver.

---
 rtl/led_palette_pkg.sv | 20 ++
 rtl/led_channel_ramp.sv | 34 +++
 rtl/led_palette_fader.sv | 154 +++++++++++++++
 tb/tb_led_palette_fader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_palette_pkg.sv
// Shared types and helpers for the LED palette fader.
package led_palette_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FADE,
    ST_DONE
  } t_fader_state;

  localparam logic [7:0] c_lsb_step = 8'd1;

  // Clocks per fade tick; clamped so the tick counter always has a period.
  function automatic int unsigned calc_step_cycles(input int unsigned fclk_hz,
                                                   input int unsigned step_us);
    int unsigned cycles;
    cycles = (fclk_hz / 1_000_000) * step_us;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/led_channel_ramp.sv
// One 8-bit palette channel that walks one LSB per tick toward a latched target.
module led_channel_ramp
  import led_palette_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic       load,
  input  logic [7:0] target,
  input  logic       tick,
  output logic [7:0] value,
  output logic       at_target
);

  logic [7:0] target_q;

  // Target latch and saturating-free ramp: comparisons keep value inside 0..255.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      target_q <= 8'd0;
      value    <= 8'd0;
    end else if (load) begin
      target_q <= target;
    end else if (tick) begin
      if (value < target_q) begin
        value <= value + c_lsb_step;
      end else if (value > target_q) begin
        value <= value - c_lsb_step;
      end
    end
  end

  assign at_target = (value == target_q);

endmodule

// File: rtl/led_palette_fader.sv
// Arbitrates two palette requesters and fades every LED channel toward the winner's targets.
// Optional round-robin arbitration: define LED_FADER_ROUND_ROBIN_EN.
module led_palette_fader
  import led_palette_pkg::*;
#(
  parameter int unsigned parm_color_led_count = 4,
  parameter int unsigned parm_basic_led_count = 4,
  parameter int unsigned parm_FCLK            = 40_000_000,
  parameter int unsigned parm_fade_step_us    = 1000
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic                              i_req0_valid,
  input  logic                              i_req1_valid,
  output logic                              o_req0_ready,
  output logic                              o_req1_ready,
  input  logic [8*parm_color_led_count-1:0] i_req0_red,
  input  logic [8*parm_color_led_count-1:0] i_req0_green,
  input  logic [8*parm_color_led_count-1:0] i_req0_blue,
  input  logic [8*parm_basic_led_count-1:0] i_req0_lumin,
  input  logic [8*parm_color_led_count-1:0] i_req1_red,
  input  logic [8*parm_color_led_count-1:0] i_req1_green,
  input  logic [8*parm_color_led_count-1:0] i_req1_blue,
  input  logic [8*parm_basic_led_count-1:0] i_req1_lumin,
  output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
  output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_grant_id
);

  localparam int unsigned c_chan_count  = 3 * parm_color_led_count + parm_basic_led_count;
  localparam int unsigned c_color_w     = 8 * parm_color_led_count;
  localparam int unsigned c_all_w       = 8 * c_chan_count;
  localparam int unsigned c_step_cycles = calc_step_cycles(parm_FCLK, parm_fade_step_us);
  localparam int unsigned c_cnt_w       = (c_step_cycles > 1) ? $clog2(c_step_cycles) : 1;

  t_fader_state state, state_nxt;

  logic               any_valid;
  logic               winner;
  logic               load;
  logic               tick;
  logic               all_at;
  logic [c_cnt_w-1:0] tick_cnt;
  logic               ready0_nxt, ready1_nxt, busy_nxt, done_nxt, grant_nxt;

  logic [c_all_w-1:0]      tgt_req0, tgt_req1, tgt_sel, val_all;
  logic [c_chan_count-1:0] at_vec;

  assign any_valid = i_req0_valid | i_req1_valid;
  assign load      = (state == ST_IDLE) && any_valid;

`ifdef LED_FADER_ROUND_ROBIN_EN
  logic rr_ptr;

  // Preferred requester flips to the other one after every grant.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rr_ptr <= 1'b0;
    end else if (load) begin
      rr_ptr <= ~winner;
    end
  end

  assign winner = (i_req0_valid && i_req1_valid) ? rr_ptr : i_req1_valid;
`else
  assign winner = ~i_req0_valid;
`endif

  assign tgt_req0 = {i_req0_lumin, i_req0_blue, i_req0_green, i_req0_red};
  assign tgt_req1 = {i_req1_lumin, i_req1_blue, i_req1_green, i_req1_red};
  assign tgt_sel  = winner ? tgt_req1 : tgt_req0;
  assign all_at   = &at_vec;
  assign tick     = (state == ST_FADE) && (tick_cnt == c_cnt_w'(c_step_cycles - 1));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_valid) state_nxt = ST_FADE;
      ST_FADE: if (all_at)    state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready0_nxt = 1'b0;
    ready1_nxt = 1'b0;
    grant_nxt  = o_grant_id;
    busy_nxt   = (state_nxt != ST_IDLE);
    done_nxt   = (state == ST_DONE);
    if (load) begin
      ready0_nxt = ~winner;
      ready1_nxt = winner;
      grant_nxt  = winner;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_req0_ready <= 1'b0;
      o_req1_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_grant_id   <= 1'b0;
    end else begin
      o_req0_ready <= ready0_nxt;
      o_req1_ready <= ready1_nxt;
      o_busy       <= busy_nxt;
      o_done       <= done_nxt;
      o_grant_id   <= grant_nxt;
    end
  end

  // Tick counter restarts on each grant so the first step lands a full period later.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tick_cnt <= '0;
    end else if (load || tick) begin
      tick_cnt <= '0;
    end else if (state == ST_FADE) begin
      tick_cnt <= tick_cnt + c_cnt_w'(1);
    end
  end

  for (genvar i = 0; i < c_chan_count; i++) begin : g_chan
    led_channel_ramp u_ramp (
      .clk       (i_clk),
      .arst_n    (i_arst_n),
      .load      (load),
      .target    (tgt_sel[8*i +: 8]),
      .tick      (tick),
      .value     (val_all[8*i +: 8]),
      .at_target (at_vec[i])
    );
  end

  assign o_color_led_red_value   = val_all[c_color_w-1:0];
  assign o_color_led_green_value = val_all[2*c_color_w-1:c_color_w];
  assign o_color_led_blue_value  = val_all[3*c_color_w-1:2*c_color_w];
  assign o_basic_led_lumin_value = val_all[c_all_w-1:3*c_color_w];

endmodule

// File: tb/tb_led_palette_fader.sv
// Randomized self-checking bench for led_palette_fader against a cycle-count palette model.
module tb_led_palette_fader;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_red, req0_green, req0_blue, req0_lumin;
  logic [7:0] req1_red, req1_green, req1_blue, req1_lumin;
  logic [7:0] red_v, green_v, blue_v, lumin_v;
  logic       busy, done, grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_cur;  // model palette {lumin, blue, green, red}
  bit          m_ptr;  // model preferred requester

  always #5 clk = ~clk;

  led_palette_fader #(
    .parm_color_led_count (1),
    .parm_basic_led_count (1),
    .parm_FCLK            (1_000_000),
    .parm_fade_step_us    (4)
  ) dut (
    .i_clk                   (clk),
    .i_arst_n                (arst_n),
    .i_req0_valid            (req0_valid),
    .i_req1_valid            (req1_valid),
    .o_req0_ready            (req0_ready),
    .o_req1_ready            (req1_ready),
    .i_req0_red              (req0_red),
    .i_req0_green            (req0_green),
    .i_req0_blue             (req0_blue),
    .i_req0_lumin            (req0_lumin),
    .i_req1_red              (req1_red),
    .i_req1_green            (req1_green),
    .i_req1_blue             (req1_blue),
    .i_req1_lumin            (req1_lumin),
    .o_color_led_red_value   (red_v),
    .o_color_led_green_value (green_v),
    .o_color_led_blue_value  (blue_v),
    .o_basic_led_lumin_value (lumin_v),
    .o_busy                  (busy),
    .o_done                  (done),
    .o_grant_id              (grant_id)
  );

  function automatic logic [31:0] dut_pal();
    return {lumin_v, blue_v, green_v, red_v};
  endfunction

  // Each byte has moved min(distance, ticks) LSBs toward its target.
  function automatic logic [31:0] model_pal(input logic [31:0] start, input logic [31:0] tgt,
                                            input int ticks);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      int s, t, d;
      s = int'(start[8*i +: 8]);
      t = int'(tgt[8*i +: 8]);
      d = (t > s) ? t - s : s - t;
      if (ticks < d) d = ticks;
      r[8*i +: 8] = (t > s) ? 8'(s + d) : 8'(s - d);
    end
    return r;
  endfunction

  function automatic int max_delta(input logic [31:0] a, input logic [31:0] b);
    int m = 0;
    for (int i = 0; i < 4; i++) begin
      int x, y, d;
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      d = (x > y) ? x - y : y - x;
      if (d > m) m = d;
    end
    return m;
  endfunction

  task automatic drive_req(input bit id, input logic [31:0] tgt);
    if (id) begin
      {req1_lumin, req1_blue, req1_green, req1_red} = tgt;
      req1_valid = 1'b1;
    end else begin
      {req0_lumin, req0_blue, req0_green, req0_red} = tgt;
      req0_valid = 1'b1;
    end
  endtask

  // Called at the negedge right after the accept edge; follows the whole fade.
  task automatic track_fade(input logic [31:0] tgt, input bit exp_id);
    int          t_done;
    logic [31:0] exp_pal;
    n_tests++;
    if (grant_id !== exp_id) begin
      n_fail++;
      $display("FAIL grant_id: got %0b expected %0b", grant_id, exp_id);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    t_done = 2 + max_delta(m_cur, tgt) * S;
    for (int k = 1; k <= t_done; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_pal = model_pal(m_cur, tgt, k / S);
      n_tests++;
      if (dut_pal() !== exp_pal) begin
        n_fail++;
        $display("FAIL palette k=%0d: got %h expected %h", k, dut_pal(), exp_pal);
      end
      n_tests++;
      if (done !== (k == t_done)) begin
        n_fail++;
        $display("FAIL done k=%0d: got %0b expected %0b", k, done, (k == t_done));
      end
      n_tests++;
      if (busy !== (k < t_done)) begin
        n_fail++;
        $display("FAIL busy k=%0d: got %0b expected %0b", k, busy, (k < t_done));
      end
      n_tests++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL ready_in_fade k=%0d: got %b expected 00", k, {req1_ready, req0_ready});
      end
    end
    m_cur = tgt;
  endtask

  task automatic accept_and_fade(input bit exp_id, input logic [31:0] tgt);
    bit got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk);
      @(negedge clk);
      got = req0_ready | req1_ready;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_timeout: got none expected req%0d", exp_id);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    n_tests++;
    if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL ready_sel: got %b expected %b", {req1_ready, req0_ready},
               (exp_id ? 2'b10 : 2'b01));
    end
    m_ptr = ~exp_id;
    track_fade(tgt, exp_id);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({dut_pal(), busy, done, grant_id, req0_ready, req1_ready} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pal=%h busy=%b done=%b", dut_pal(), busy, done);
    end
    @(negedge clk);
    arst_n = 1'b1;
    m_cur = 32'd0;
    m_ptr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({dut_pal(), busy, done, req0_ready, req1_ready} !== 36'd0) begin
        n_fail++;
        $display("FAIL idle k=%0d: got pal=%h busy=%b done=%b", k, dut_pal(), busy, done);
      end
    end
  endtask

  task automatic test_single();
    drive_req(1'b0, 32'h0000_0003);
    accept_and_fade(1'b0, 32'h0000_0003);
  endtask

  task automatic test_two_channel();
    drive_req(1'b1, 32'h0200_0000);
    accept_and_fade(1'b1, 32'h0200_0000);
  endtask

  task automatic test_both_valid();
    logic [31:0] t0, t1;
    bit          exp_id;
    for (int r = 0; r < 2; r++) begin
      t0 = 32'h0105_0A00 + 32'(r);
      t1 = 32'h0704_0203 + 32'(r);
      drive_req(1'b0, t0);
      drive_req(1'b1, t1);
`ifdef LED_FADER_ROUND_ROBIN_EN
      exp_id = m_ptr;
`else
      exp_id = 1'b0;
`endif
      accept_and_fade(exp_id, exp_id ? t1 : t0);
    end
  endtask

  task automatic test_equal();
    drive_req(1'b1, m_cur);
    accept_and_fade(1'b1, m_cur);
  endtask

  task automatic test_random();
    bit          id;
    logic [31:0] tgt;
    for (int r = 0; r < 6; r++) begin
      id  = 1'($urandom_range(0, 1));
      tgt = $urandom;
      drive_req(id, tgt);
      accept_and_fade(id, tgt);
    end
  endtask

  task automatic test_reset_midfade();
    bit got = 1'b0;
    drive_req(1'b0, 32'h0000_0080);
    accept_and_fade(1'b0, 32'h0000_0080);
    drive_req(1'b0, 32'h0000_00FF);
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk);
      @(negedge clk);
      got = req0_ready;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL midfade_accept: got no ready0 expected ready0");
    end
    repeat (16 * S) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_tests++;
    if (dut_pal() !== 32'h0000_0090) begin
      n_fail++;
      $display("FAIL midfade_value: got %h expected 00000090", dut_pal());
    end
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({dut_pal(), busy, done, grant_id, req0_ready, req1_ready} !== 37'd0) begin
      n_fail++;
      $display("FAIL midfade_reset: got pal=%h busy=%b done=%b", dut_pal(), busy, done);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({done, busy, req0_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL in_reset k=%0d: got done=%b busy=%b ready0=%b", k, done, busy, req0_ready);
      end
    end
    arst_n = 1'b1;
    m_cur  = 32'd0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reaccept: got %b expected 01", {req1_ready, req0_ready});
    end
    m_ptr = 1'b1;
    track_fade(32'h0000_00FF, 1'b0);
  endtask

  initial begin
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    {req0_lumin, req0_blue, req0_green, req0_red} = 32'd0;
    {req1_lumin, req1_blue, req1_green, req1_red} = 32'd0;
    test_reset();
    test_single();
    test_two_channel();
    test_both_valid();
    test_equal();
    test_random();
    test_reset_midfade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
